// File: rtl/dm_cache_controller.sv
// rtl/dm_cache_controller.sv - direct-mapped write-back/write-allocate cache controller
// Owns tag/valid/dirty/data arrays and sequences hit, writeback and refill.
module dm_cache_controller #(
  parameter int WORD_SIZE       = 32,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int NUM_CACHE_LINES = 8,
  parameter int ADDR_LENGTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_LENGTH-1:0]     cpu_addr,
  input  logic [WORD_SIZE-1:0]       cpu_wdata,
  output logic [WORD_SIZE-1:0]       cpu_rdata,
  output logic                       cpu_ready,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_LENGTH-1:0]     mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rdata,
  input  logic                       mem_ack,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
);

  localparam int IDX_W  = $clog2(NUM_CACHE_LINES);
  localparam int OFF_W  = $clog2(CACHE_LINE_SIZE / 8);
  localparam int TAG_W  = ADDR_LENGTH - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(CACHE_LINE_SIZE / WORD_SIZE);
  localparam int BSEL_W = OFF_W - WSEL_W;
  localparam int WBIT_W = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t                     state;
  logic                       req_we;
  logic [ADDR_LENGTH-1:0]     req_addr;
  logic [WORD_SIZE-1:0]       req_wdata;
  logic                       refilled;

  logic [TAG_W-1:0]           tag_arr  [NUM_CACHE_LINES];
  logic [CACHE_LINE_SIZE-1:0] data_arr [NUM_CACHE_LINES];
  logic [NUM_CACHE_LINES-1:0] valid;
  logic [NUM_CACHE_LINES-1:0] dirty;

  logic [IDX_W-1:0]           req_idx;
  logic [TAG_W-1:0]           req_tag;
  logic [WSEL_W-1:0]          req_wsel;
  logic [CACHE_LINE_SIZE-1:0] cur_line;
  logic [CACHE_LINE_SIZE-1:0] wr_line;
  logic [TAG_W-1:0]           cur_tag;
  logic [WORD_SIZE-1:0]       cur_word;
  logic                       hit;

  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[ADDR_LENGTH-1 -: TAG_W];
  assign req_wsel = req_addr[BSEL_W +: WSEL_W];
  assign cur_line = data_arr[req_idx];
  assign cur_tag  = tag_arr[req_idx];
  assign hit      = valid[req_idx] && (cur_tag == req_tag);
  assign cur_word = cur_line[{req_wsel, {WBIT_W{1'b0}}} +: WORD_SIZE];

  // Line image with the CPU write word merged in; only stored on a write hit.
  always_comb begin
    wr_line = cur_line;
    wr_line[{req_wsel, {WBIT_W{1'b0}}} +: WORD_SIZE] = req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      refilled   <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          // A request still high during the completion pulse is the old one.
          if (cpu_req && !cpu_ready) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          refilled <= 1'b0;
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= cur_word;
            if (req_we) begin
              data_arr[req_idx] <= wr_line;
              dirty[req_idx]    <= 1'b1;
            end
            // The compare right after a refill was already counted as a miss.
            if (!refilled && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            state <= IDLE;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            mem_req <= 1'b1;
            if (valid[req_idx] && dirty[req_idx]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {cur_tag, req_idx, {OFF_W{1'b0}}};
              mem_wdata <= cur_line;
              state     <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
            state    <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            data_arr[req_idx] <= mem_rdata;
            tag_arr[req_idx]  <= req_tag;
            valid[req_idx]    <= 1'b1;
            dirty[req_idx]    <= 1'b0;
            mem_req           <= 1'b0;
            refilled          <= 1'b1;
            state             <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// tb/tb_dm_cache_controller.sv - scoreboard bench for dm_cache_controller
// Stimulus pushes expected CPU/memory transactions; monitors pop and compare.
module tb_dm_cache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_req;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  dm_cache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        chk_data;
    logic [31:0] rdata;
    int          lat;
  } cpu_exp_t;

  typedef struct {
    logic         we;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  cpu_exp_t ce;
  mem_exp_t me;
  int       req_t0 = 0;

  localparam int ACK_DELAY = 1;
  logic hold_ack = 1'b0;
  logic req_prev = 1'b0;
  logic ack_prev = 1'b0;
  int   wait_cnt = 0;

  function automatic logic [127:0] line_for(input logic [15:0] a);
    case (a)
      16'h0010: line_for = 128'h33333333_22222222_DEADBEEF_DEADBEEF;
      16'h0090: line_for = 128'h44444444_55555555_66666666_77777777;
      16'h00A0: line_for = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
      default:  line_for = '0;
    endcase
  endfunction

  // CPU response monitor
  always @(negedge clk) begin
    if (cpu_ready) begin
      if (cpu_q.size() == 0) begin
        check("unexpected_cpu_ready", 1'b1, 1'b0);
      end else begin
        ce = cpu_q.pop_front();
        check("cpu_latency", cyc - req_t0, ce.lat);
        if (ce.chk_data) check("cpu_rdata", cpu_rdata, ce.rdata);
      end
    end
  end

  // Memory phase monitor followed by the responder for the same cycle
  always @(negedge clk) begin
    if (mem_req && (!req_prev || ack_prev)) begin
      if (mem_q.size() == 0) begin
        check("unexpected_mem_req", 1'b1, 1'b0);
      end else begin
        me = mem_q.pop_front();
        check("mem_we", mem_we, me.we);
        check("mem_addr", mem_addr, me.addr);
        if (me.we) check("mem_wdata", mem_wdata, me.wdata);
      end
    end
    req_prev = mem_req;
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (!mem_req) begin
      wait_cnt = 0;
    end else if (!hold_ack) begin
      if (wait_cnt >= ACK_DELAY) begin
        mem_ack   = 1'b1;
        mem_rdata = line_for(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
    ack_prev = mem_ack;
  end

  task automatic expect_mem(input logic we, input logic [15:0] a, input logic [127:0] wd);
    mem_exp_t e;
    e.we = we;
    e.addr = a;
    e.wdata = wd;
    mem_q.push_back(e);
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                            input logic chk, input logic [31:0] exp_rd, input int lat);
    cpu_exp_t e;
    e.chk_data = chk;
    e.rdata = exp_rd;
    e.lat = lat;
    cpu_q.push_back(e);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    req_t0    = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_ready) break;
    end
    check("cpu_ready_seen", cpu_ready, 1'b1);
    cpu_req = 1'b0;
  endtask

  int unstable;

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_hit_count", hit_count, 16'h0);
    check("rst_miss_count", miss_count, 16'h0);
    rst = 1'b0;

    // Cold miss, ack in cycle 3, completion in cycle 5
    expect_mem(1'b0, 16'h0010, '0);
    cpu_access(1'b0, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF, 5);
    check("t1_miss_count", miss_count, 16'd1);
    check("t1_hit_count", hit_count, 16'd0);

    // Hits on the refilled line, then a write hit to word 2
    cpu_access(1'b0, 16'h0014, 32'h0, 1'b1, 32'hDEADBEEF, 2);
    check("t2_hit_count", hit_count, 16'd1);
    cpu_access(1'b0, 16'h001C, 32'h0, 1'b1, 32'h33333333, 2);
    cpu_access(1'b0, 16'h0018, 32'h0, 1'b1, 32'h22222222, 2);
    cpu_access(1'b1, 16'h0018, 32'h12345678, 1'b0, 32'h0, 2);
    check("t3_hit_after_write", hit_count, 16'd4);

    // Conflict miss on a dirty line: writeback then fetch
    expect_mem(1'b1, 16'h0010, 128'h33333333_12345678_DEADBEEF_DEADBEEF);
    expect_mem(1'b0, 16'h0090, '0);
    cpu_access(1'b0, 16'h0098, 32'h0, 1'b1, 32'h55555555, 8);
    check("t3_miss_count", miss_count, 16'd2);
    check("t3_hit_count", hit_count, 16'd4);
    cpu_access(1'b0, 16'h0090, 32'h0, 1'b1, 32'h77777777, 2);
    check("t3_hit_new_line", hit_count, 16'd5);

    // Stalled refill: request held, no completion
    hold_ack = 1'b1;
    expect_mem(1'b0, 16'h00A0, '0);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h00A0;
    req_t0   = cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check("t4_mem_req_up", mem_req, 1'b1);
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== 16'h00A0 || cpu_ready !== 1'b0) unstable++;
    end
    check("t4_stall_unstable_cycles", unstable, 0);

    // Reset mid-refill aborts the request
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("t5_mem_req_drop", mem_req, 1'b0);
    check("t5_no_cpu_ready", cpu_ready, 1'b0);
    check("t5_miss_count_rst", miss_count, 16'd0);
    rst = 1'b0;
    hold_ack = 1'b0;
    expect_mem(1'b0, 16'h0090, '0);
    cpu_access(1'b0, 16'h0098, 32'h0, 1'b1, 32'h55555555, 5);
    check("t5_remiss_count", miss_count, 16'd1);
    check("t5_hit_count", hit_count, 16'd0);

    // Hit counter saturation
    @(negedge clk);
    force dut.hit_count = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count;
    cpu_access(1'b0, 16'h0094, 32'h0, 1'b1, 32'h66666666, 2);
    check("t6_hit_reach_max", hit_count, 16'hFFFF);
    cpu_access(1'b0, 16'h009C, 32'h0, 1'b1, 32'h44444444, 2);
    check("t6_hit_saturated", hit_count, 16'hFFFF);

    repeat (3) @(negedge clk);
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
